net_engine_win_gen: RTL and testbench



---
 rtl/net_engine_pkg.sv | 26 ++
 rtl/net_engine_line_buf.sv | 39 +++
 rtl/net_engine_win_gen.sv | 166 ++++++++++++++++
 tb/tb_net_engine_win_gen.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/net_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module      : net_engine_pkg
// Description : Shared constants and helpers for the net_engine window path.
//               KERNEL_DIM/WIN_ELEMS describe the 3x3 neighbourhood, win_idx()
//               maps (row, column) to the flat window element index and
//               cnt_width() sizes the row/column position counters.
// Revision    : 1.0 - initial release
// ============================================================================
package net_engine_pkg;

  localparam int KERNEL_DIM = 3;
  localparam int WIN_ELEMS  = KERNEL_DIM * KERNEL_DIM;

  // Flat element index of window position (r, c); r=0 oldest row, c=0 oldest column.
  function automatic int win_idx(input int r, input int c);
    return r * KERNEL_DIM + c;
  endfunction

  // Bits needed to count 0..n-1 (never less than one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/net_engine_line_buf.sv
`default_nettype none
// ============================================================================
// Module      : net_engine_line_buf
// Description : One image row of pixel storage. Single access per cycle,
//               read-then-write: rdata is a combinational read of addr, and
//               a write on the same address lands at the clock edge, so the
//               same cycle still observes the previous contents.
// Ports       : s00_axis_aclk - clock
//               we            - write enable
//               addr          - column address (read and write)
//               wdata         - data written at addr when we=1
//               rdata         - current contents at addr
// Revision    : 1.0 - initial release
// ============================================================================
module net_engine_line_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 28,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  s00_axis_aclk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  // No reset: contents are always written before they are read back.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  assign rdata = r_mem[addr];

  always_ff @(posedge s00_axis_aclk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
  end

endmodule
`default_nettype wire

// File: rtl/net_engine_win_gen.sv
`default_nettype none
// ============================================================================
// Module      : net_engine_win_gen
// Description : Sliding 3x3 window generator. Consumes a row-major pixel
//               stream and emits one full neighbourhood per accepted pixel
//               once two rows and two columns are buffered (valid windows
//               only, no padding). Two line buffers hold the previous rows.
// Ports       : s00_axis_aclk    - clock
//               s00_axis_aresetn - asynchronous active-low reset
//               s_axis_tdata/tvalid/tlast/tready - pixel input stream
//               win_data/win_valid/win_last/win_ready - window output stream
//               busy             - a frame is partially received
//               frame_err        - (NET_ENGINE_WIN_FRAME_CHECK_EN only) sticky
//                                  tlast/position disagreement flag
// Options     : NET_ENGINE_WIN_FRAME_CHECK_EN - enables tlast checking and
//               resynchronisation of the position counters on early tlast.
// Revision    : 1.0 - initial release
// ============================================================================
module net_engine_win_gen
  import net_engine_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic                          s00_axis_aclk,
  input  logic                          s00_axis_aresetn,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready,
  output logic [WIN_ELEMS*DATA_WIDTH-1:0] win_data,
  output logic                          win_valid,
  output logic                          win_last,
  input  logic                          win_ready,
`ifdef NET_ENGINE_WIN_FRAME_CHECK_EN
  output logic                          frame_err,
`endif
  output logic                          busy
);

  localparam int c_COL_W = cnt_width(IMG_WIDTH);
  localparam int c_ROW_W = cnt_width(IMG_HEIGHT);
  localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_WIDTH - 1);
  localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IMG_HEIGHT - 1);
  localparam logic [c_COL_W-1:0] c_COL_TWO  = c_COL_W'(2);
  localparam logic [c_ROW_W-1:0] c_ROW_TWO  = c_ROW_W'(2);

  logic [c_COL_W-1:0]    r_col;
  logic [c_ROW_W-1:0]    r_row;
  logic                  r_in_en;
  logic                  r_valid;
  logic                  r_last;
  logic [DATA_WIDTH-1:0] r_win [WIN_ELEMS];
  logic [DATA_WIDTH-1:0] w_lb0_rd;
  logic [DATA_WIDTH-1:0] w_lb1_rd;
  logic                  w_accept;
  logic                  w_last_pos;
  logic                  w_resync;

  // r_in_en keeps tready low through reset and the edge that releases it.
  assign s_axis_tready = r_in_en && (!r_valid || win_ready);
  assign w_accept      = s_axis_tvalid && s_axis_tready;
  assign w_last_pos    = (r_row == c_ROW_LAST) && (r_col == c_COL_LAST);
  assign busy          = (r_row != '0) || (r_col != '0);
  assign win_valid     = r_valid;
  assign win_last      = r_last;

  // lb0 holds the previous row, lb1 the row before that.
  net_engine_line_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (IMG_WIDTH),
    .ADDR_WIDTH (c_COL_W)
  ) u_lb0 (
    .s00_axis_aclk (s00_axis_aclk),
    .we            (w_accept),
    .addr          (r_col),
    .wdata         (s_axis_tdata),
    .rdata         (w_lb0_rd)
  );

  net_engine_line_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (IMG_WIDTH),
    .ADDR_WIDTH (c_COL_W)
  ) u_lb1 (
    .s00_axis_aclk (s00_axis_aclk),
    .we            (w_accept),
    .addr          (r_col),
    .wdata         (w_lb0_rd),
    .rdata         (w_lb1_rd)
  );

`ifdef NET_ENGINE_WIN_FRAME_CHECK_EN
  // An early tlast restarts the position counters after that beat.
  assign w_resync = s_axis_tlast && !w_last_pos;

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      frame_err <= 1'b0;
    end else if (w_accept && (s_axis_tlast != w_last_pos)) begin
      frame_err <= 1'b1;
    end
  end
`else
  // Frame position comes from the counters alone; tlast is not used.
  logic w_unused_tlast;
  assign w_unused_tlast = s_axis_tlast;
  assign w_resync       = 1'b0;
`endif

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      r_in_en <= 1'b0;
      r_col   <= '0;
      r_row   <= '0;
    end else begin
      r_in_en <= 1'b1;
      if (w_accept) begin
        if (w_last_pos || w_resync) begin
          r_col <= '0;
          r_row <= '0;
        end else if (r_col == c_COL_LAST) begin
          r_col <= '0;
          r_row <= r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  // Columns crossing a row boundary hold stale data, but col<2 never
  // raises win_valid so they are not exposed.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      for (int i = 0; i < WIN_ELEMS; i++) begin
        r_win[i] <= '0;
      end
    end else if (w_accept) begin
      for (int r = 0; r < KERNEL_DIM; r++) begin
        for (int c = 0; c < KERNEL_DIM - 1; c++) begin
          r_win[win_idx(r, c)] <= r_win[win_idx(r, c + 1)];
        end
      end
      r_win[win_idx(0, 2)] <= w_lb1_rd;
      r_win[win_idx(1, 2)] <= w_lb0_rd;
      r_win[win_idx(2, 2)] <= s_axis_tdata;
      r_valid <= (r_row >= c_ROW_TWO) && (r_col >= c_COL_TWO);
      r_last  <= w_last_pos;
    end else if (r_valid && win_ready) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  generate
    for (genvar i = 0; i < WIN_ELEMS; i++) begin : g_pack
      assign win_data[i*DATA_WIDTH +: DATA_WIDTH] = r_win[i];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_net_engine_win_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_net_engine_win_gen
// Description : Self-checking bench for net_engine_win_gen. A 5x5 instance
//               and a default 28x28 instance are each checked every cycle
//               against a reference model that stores the received image
//               and cuts expected 3x3 windows from it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_net_engine_win_gen;

  localparam int DW = 32;
  localparam int W0 = 5, H0 = 5, W1 = 28, H1 = 28;

  typedef struct {
    logic [9*DW-1:0] data;
    logic            last;
  } win_t;

  logic s00_axis_aclk = 1'b0;
  always #5 s00_axis_aclk = ~s00_axis_aclk;

  logic          s00_axis_aresetn;
  logic [DW-1:0] tdata;
  logic          tvalid, tlast, win_ready;
  int            sel;
  logic          tvalid0, tvalid1;
  logic          tready0, tready1, wvalid0, wvalid1, wlast0, wlast1, busy0, busy1;
  logic          ferr0, ferr1;
  logic [9*DW-1:0] wdata0, wdata1;

  assign tvalid0 = tvalid && (sel == 0);
  assign tvalid1 = tvalid && (sel == 1);

  net_engine_win_gen #(.DATA_WIDTH(DW), .IMG_WIDTH(W0), .IMG_HEIGHT(H0)) u_dut5 (
    .s00_axis_aclk(s00_axis_aclk), .s00_axis_aresetn(s00_axis_aresetn),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid0), .s_axis_tlast(tlast),
    .s_axis_tready(tready0), .win_data(wdata0), .win_valid(wvalid0),
    .win_last(wlast0), .win_ready(win_ready),
`ifdef NET_ENGINE_WIN_FRAME_CHECK_EN
    .frame_err(ferr0),
`endif
    .busy(busy0));

  net_engine_win_gen #(.DATA_WIDTH(DW)) u_dut28 (
    .s00_axis_aclk(s00_axis_aclk), .s00_axis_aresetn(s00_axis_aresetn),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid1), .s_axis_tlast(tlast),
    .s_axis_tready(tready1), .win_data(wdata1), .win_valid(wvalid1),
    .win_last(wlast1), .win_ready(win_ready),
`ifdef NET_ENGINE_WIN_FRAME_CHECK_EN
    .frame_err(ferr1),
`endif
    .busy(busy1));

`ifndef NET_ENGINE_WIN_FRAME_CHECK_EN
  assign ferr0 = 1'b0;
  assign ferr1 = 1'b0;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  // ---------------- comparison helpers ----------------
  task automatic chkw(input string nm, input logic [9*DW-1:0] act, input logic [9*DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  win_t          q0[$], q1[$], obs0[$];
  int            mrow[2], mcol[2];
  logic          merr[2];
  logic [DW-1:0] img[2][28][28];
  logic          pe = 1'b0;
  int            n_win1 = 0;

  always @(posedge s00_axis_aclk) pe <= s00_axis_aresetn;

  task automatic model_accept(input int d, input logic [DW-1:0] px, input logic tl);
    int   w, h, r, c;
    logic lp;
    win_t nw;
    w = (d == 0) ? W0 : W1;
    h = (d == 0) ? H0 : H1;
    r = mrow[d];
    c = mcol[d];
    img[d][r][c] = px;
    lp = (r == h - 1) && (c == w - 1);
    if (r >= 2 && c >= 2) begin
      nw.data = '0;
      for (int rr = 0; rr < 3; rr++)
        for (int cc = 0; cc < 3; cc++)
          nw.data[(rr*3+cc)*DW +: DW] = img[d][r-2+rr][c-2+cc];
      nw.last = lp;
      if (d == 0) q0.push_back(nw); else q1.push_back(nw);
    end
`ifdef NET_ENGINE_WIN_FRAME_CHECK_EN
    if (tl != lp) merr[d] = 1'b1;
    if (tl && !lp) begin
      mrow[d] = 0;
      mcol[d] = 0;
      return;
    end
`else
    if (tl) merr[d] = merr[d];
`endif
    if (c == w - 1) begin
      mcol[d] = 0;
      mrow[d] = (r == h - 1) ? 0 : r + 1;
    end else begin
      mcol[d] = c + 1;
    end
  endtask

  task automatic check_dut(input int d, input logic vld, input logic [9*DW-1:0] data,
                           input logic last, input logic trdy, input logic bsy,
                           input logic ferr, input logic tv);
    string nm;
    int    qs;
    win_t  f;
    nm = (d == 0) ? "dut5" : "dut28";
    if (!s00_axis_aresetn) begin
      chk1({nm, "_rst_win_valid"}, vld, 1'b0);
      chk1({nm, "_rst_win_last"}, last, 1'b0);
      chkw({nm, "_rst_win_data"}, data, '0);
      chk1({nm, "_rst_busy"}, bsy, 1'b0);
      chk1({nm, "_rst_tready"}, trdy, 1'b0);
      if (d == 0) q0.delete(); else q1.delete();
      mrow[d] = 0;
      mcol[d] = 0;
      merr[d] = 1'b0;
    end else begin
      chk1({nm, "_busy"}, bsy, (mrow[d] != 0) || (mcol[d] != 0));
      chk1({nm, "_tready"}, trdy, pe && (!vld || win_ready));
`ifdef NET_ENGINE_WIN_FRAME_CHECK_EN
      chk1({nm, "_frame_err"}, ferr, merr[d]);
`else
      if (ferr) chk1({nm, "_frame_err"}, ferr, 1'b0);
`endif
      qs = (d == 0) ? q0.size() : q1.size();
      if (vld) begin
        if (qs == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL %s_spurious_window: got win_valid=1 required no window", nm);
        end else begin
          f = (d == 0) ? q0[0] : q1[0];
          chkw({nm, "_win_data"}, data, f.data);
          chk1({nm, "_win_last"}, last, f.last);
          if (win_ready) begin
            if (d == 0) begin
              void'(q0.pop_front());
              obs0.push_back(f);
            end else begin
              void'(q1.pop_front());
              n_win1++;
            end
          end
        end
      end else if (qs != 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL %s_missing_window: got win_valid=0 required 1", nm);
      end
      if (tv && trdy) model_accept(d, tdata, tlast);
    end
  endtask

  always @(negedge s00_axis_aclk) begin
    check_dut(0, wvalid0, wdata0, wlast0, tready0, busy0, ferr0, tvalid0);
    check_dut(1, wvalid1, wdata1, wlast1, tready1, busy1, ferr1, tvalid1);
  end

  // ---------------- consumer ----------------
  int rmode = 0;
  int rcnt = 0;
  always begin
    @(posedge s00_axis_aclk);
    #1;
    case (rmode)
      0:       win_ready = 1'b1;
      1:       begin win_ready = (rcnt % 3 == 0); rcnt++; end
      default: win_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // ---------------- producer ----------------
  task automatic send_beat(input logic [DW-1:0] px, input logic tl, input bit rnd);
    int guard;
    bit ok;
    guard = 0;
    ok = 0;
    if (rnd && $urandom_range(0, 2) == 0) begin
      tvalid = 1'b0;
      @(posedge s00_axis_aclk);
      #1;
    end
    tvalid = 1'b1;
    tdata  = px;
    tlast  = tl;
    do begin
      @(negedge s00_axis_aclk);
      ok = (sel == 0) ? tready0 : tready1;
      @(posedge s00_axis_aclk);
      #1;
      guard++;
    end while (!ok && guard < 200);
    if (!ok) chk1("beat_accept_timeout", 1'b0, 1'b1);
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic send_seq(input int base, input int n, input int last_idx);
    for (int i = 0; i < n; i++) send_beat(DW'(base + i), (i == last_idx), 1'b0);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((q0.size() != 0 || q1.size() != 0 || wvalid0 || wvalid1) && guard < 500) begin
      @(posedge s00_axis_aclk);
      #1;
      guard++;
    end
    if (guard >= 500) chk1("drain_timeout", 1'b0, 1'b1);
  endtask

  // Literal 5x5 window whose oldest element (0,0) is pixel value b.
  function automatic logic [9*DW-1:0] mkwin(input int b);
    logic [9*DW-1:0] v;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        v[(r*3+c)*DW +: DW] = DW'(b + r * 5 + c);
    return v;
  endfunction

  task automatic check_run(input string tag, input int off, input int base);
    for (int k = 0; k < 9; k++) begin
      chkw($sformatf("%s_win%0d_data", tag, k), obs0[off+k].data, mkwin(base + (k / 3) * 5 + k % 3));
      chk1($sformatf("%s_win%0d_last", tag, k), obs0[off+k].last, k == 8);
    end
  endtask

  initial begin
    s00_axis_aresetn = 1'b0;
    tvalid = 1'b0;
    tdata  = '0;
    tlast  = 1'b0;
    win_ready = 1'b1;
    sel = 0;
    mrow = '{0, 0};
    mcol = '{0, 0};
    merr = '{1'b0, 1'b0};
    repeat (3) @(posedge s00_axis_aclk);
    #1;
    s00_axis_aresetn = 1'b1;
    @(posedge s00_axis_aclk);
    #1;

    // single 5x5 frame, consumer always ready
    send_seq(0, 25, 24);
    drain();
    chki("frame1_window_count", obs0.size(), 9);
    if (obs0.size() == 9) begin
      chkw("frame1_first_window", obs0[0].data, {32'd12, 32'd11, 32'd10, 32'd7, 32'd6, 32'd5, 32'd2, 32'd1, 32'd0});
      chkw("frame1_last_window", obs0[8].data, {32'd24, 32'd23, 32'd22, 32'd19, 32'd18, 32'd17, 32'd14, 32'd13, 32'd12});
      check_run("frame1", 0, 0);
    end
    obs0.delete();

    // same frame, consumer ready one cycle in three
    rmode = 1;
    send_seq(0, 25, 24);
    drain();
    rmode = 0;
    chki("stall_window_count", obs0.size(), 9);
    if (obs0.size() == 9) check_run("stall", 0, 0);
    obs0.delete();

    // two back-to-back frames
    send_seq(0, 25, 24);
    send_seq(100, 25, 24);
    drain();
    chki("b2b_window_count", obs0.size(), 18);
    if (obs0.size() == 18) begin
      chkw("b2b_frame2_first", obs0[9].data, {32'd112, 32'd111, 32'd110, 32'd107, 32'd106, 32'd105, 32'd102, 32'd101, 32'd100});
      check_run("b2b_f1", 0, 0);
      check_run("b2b_f2", 9, 100);
    end

    // reset in the middle of a frame
    send_seq(0, 14, -1);
    s00_axis_aresetn = 1'b0;
    repeat (3) @(posedge s00_axis_aclk);
    #1;
    s00_axis_aresetn = 1'b1;
    @(posedge s00_axis_aclk);
    #1;
    obs0.delete();
    send_seq(0, 25, 24);
    drain();
    chki("after_reset_window_count", obs0.size(), 9);
    if (obs0.size() == 9) check_run("after_reset", 0, 0);
    obs0.delete();

`ifdef NET_ENGINE_WIN_FRAME_CHECK_EN
    // early tlast on pixel 19, then a correct frame
    send_seq(0, 20, 19);
    drain();
    chk1("early_tlast_frame_err", ferr0, 1'b1);
    obs0.delete();
    send_seq(0, 25, 24);
    drain();
    chk1("frame_err_sticky", ferr0, 1'b1);
    chki("resync_window_count", obs0.size(), 9);
    if (obs0.size() == 9) check_run("resync", 0, 0);
    obs0.delete();
`endif

    // 28x28, random data, random tvalid gaps and random consumer
    sel = 1;
    rmode = 2;
    for (int i = 0; i < W1 * H1; i++) send_beat($urandom, (i == W1 * H1 - 1), 1'b1);
    drain();
    rmode = 0;
    chki("dut28_window_count", n_win1, (H1 - 2) * (W1 - 2));

    repeat (2) @(posedge s00_axis_aclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
